// File: rtl/hotkey_ctl_pkg.sv
// Shared types for the joypad hotkey controller: event codes and the slice of
// system configuration the controller consumes.
package hotkey_ctl_pkg;

  // Width of the debounce scan counter (DEB_SCANS tops out at 15).
  localparam int unsigned DebW = 4;

  typedef enum logic [1:0] {
    EvtNone = 2'd0,
    EvtSave = 2'd1,
    EvtLoad = 2'd2,
    EvtMenu = 2'd3
  } HkEvt;

  typedef struct packed {
    logic [7:0] key_save;
    logic [7:0] key_load;
    logic [7:0] key_menu;
    logic       ct_sst_on;
  } SysCfg;

endpackage

// File: rtl/hotkey_ctl.sv
// Hotkey controller: debounces joypad combos, raises an event to the MCU and
// waits for ack (or timeout), then waits for all keys released before rearming.
module hotkey_ctl
  import hotkey_ctl_pkg::*;
#(
  parameter int unsigned DEB_SCANS = 3,
  parameter int unsigned ACK_TMO   = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  SysCfg      cfg,
  input  logic       joy_strobe,
  input  logic [7:0] joy_keys,
  input  logic       evt_ack,
  output logic       evt_req,
  output HkEvt       evt_code,
  output logic       evt_tmo,
  output logic       busy
);

  localparam int unsigned TmoW = (ACK_TMO > 1) ? $clog2(ACK_TMO) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(ACK_TMO - 1);
  localparam logic [DebW-1:0] DebLast = DebW'(DEB_SCANS);

  typedef enum logic [1:0] {
    StIdle,
    StDebounce,
    StFire,
    StRelease
  } state_e;

  state_e          state_q;
  logic [DebW-1:0] deb_cnt_q;
  logic [TmoW-1:0] tmo_cnt_q;
  HkEvt            cand_q;
  logic            evt_req_q;
  HkEvt            evt_code_q;
  logic            evt_tmo_q;
  HkEvt            hit_code;

  // Decode which code the current joypad pattern selects; later ifs win, giving
  // menu > load > save.
  always_comb begin
    hit_code = EvtNone;
    if (cfg.ct_sst_on && (cfg.key_save != 8'h00) && (joy_keys == cfg.key_save)) begin
      hit_code = EvtSave;
    end
    if (cfg.ct_sst_on && (cfg.key_load != 8'h00) && (joy_keys == cfg.key_load)) begin
      hit_code = EvtLoad;
    end
    if ((cfg.key_menu != 8'h00) && (joy_keys == cfg.key_menu)) begin
      hit_code = EvtMenu;
    end
  end

  // Control FSM with registered event outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      deb_cnt_q  <= '0;
      tmo_cnt_q  <= '0;
      cand_q     <= EvtNone;
      evt_req_q  <= 1'b0;
      evt_code_q <= EvtNone;
      evt_tmo_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (joy_strobe && (hit_code != EvtNone)) begin
            cand_q    <= hit_code;
            deb_cnt_q <= DebW'(1);
            if (DEB_SCANS == 1) begin
              state_q    <= StFire;
              evt_req_q  <= 1'b1;
              evt_code_q <= hit_code;
              evt_tmo_q  <= 1'b0;
              tmo_cnt_q  <= '0;
            end else begin
              state_q <= StDebounce;
            end
          end
        end
        StDebounce: begin
          if (joy_strobe) begin
            if (hit_code == cand_q) begin
              deb_cnt_q <= deb_cnt_q + DebW'(1);
              if ((deb_cnt_q + DebW'(1)) == DebLast) begin
                state_q    <= StFire;
                evt_req_q  <= 1'b1;
                evt_code_q <= cand_q;
                evt_tmo_q  <= 1'b0;
                tmo_cnt_q  <= '0;
              end
            end else begin
              // Any break in the streak abandons the candidate.
              state_q   <= StIdle;
              deb_cnt_q <= '0;
            end
          end
        end
        StFire: begin
          // Ack wins over a coincident timeout.
          if (evt_ack) begin
            evt_req_q <= 1'b0;
            state_q   <= StRelease;
          end else if (tmo_cnt_q == TmoLast) begin
            evt_req_q <= 1'b0;
            evt_tmo_q <= 1'b1;
            state_q   <= StRelease;
          end else if (tmo_cnt_q != '1) begin
            tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
          end
        end
        StRelease: begin
          if (joy_strobe && (joy_keys == 8'h00)) begin
            state_q   <= StIdle;
            deb_cnt_q <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign evt_req  = evt_req_q;
  assign evt_code = evt_code_q;
  assign evt_tmo  = evt_tmo_q;
  assign busy     = (state_q != StIdle);

endmodule
